phase_timer: RTL and testbench
==============================

PHASE_TIMER -- requirements
Module: phase_timer

Parameters
REQ-001 The block SHALL have parameter TVALUE, default 4, giving the base phase length in clk cycles (legal range 1..255).
REQ-002 The block SHALL have a derived localparam CW, equal to clog2(3*TVALUE+1), giving the count width in bits.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port tr, input, 1 bit: timer restart request from the crosswalk FSM.
REQ-006 The block SHALL have port multiplier, input, 2 bits: phase length multiplier, sampled only while tr=1.
REQ-007 The block SHALL have port hold, input, 1 bit: pause counting while in RUN.
REQ-008 The block SHALL have port cf, output, 1 bit: count finished; level signal.
REQ-009 The block SHALL have port done_pulse, output, 1 bit: one-cycle strobe on entry to DONE.
REQ-010 The block SHALL have port busy, output, 1 bit: high iff state is RUN.
REQ-011 The block SHALL have port count, output, CW bits: elapsed counting edges since the last restart.

Function
REQ-012 The block SHALL implement a registered FSM with states IDLE, RUN and DONE; all outputs SHALL be driven from registers.
REQ-013 Terminal SHALL be computed as TVALUE*mult_q at full CW width with no truncation, where mult_q is the latched multiplier.
REQ-014 Any edge with tr=1, in any state, SHALL latch multiplier into mult_q, set count=0 and clear cf.
- Next state on that edge SHALL be RUN if multiplier!=0.
- Next state on that edge SHALL be DONE if multiplier==0.
REQ-015 While tr stays high, the block SHALL re-apply REQ-014 every edge, so count stays 0; restart dominates hold and completion.
REQ-016 In RUN with tr=0 and hold=0, each edge SHALL increment count by 1.
REQ-017 In RUN with tr=0 and hold=1, count and state SHALL be frozen.
REQ-018 The edge on which the incremented count equals terminal SHALL move the state to DONE, set cf=1 and set done_pulse=1.
- Hence cf rises exactly terminal non-held counting edges after tr falls.
REQ-019 When multiplier==0 is sampled, the tr edge SHALL itself enter DONE with cf=1 and done_pulse=1.
REQ-020 In DONE, cf SHALL stay 1 and count SHALL hold at terminal until the next tr=1 edge.
- hold SHALL be ignored in DONE.
- count SHALL never wrap.
REQ-021 done_pulse SHALL be high for exactly one cycle per DONE entry, then 0.
- If tr=1 in DONE re-enters DONE (multiplier==0), done_pulse SHALL pulse again.
REQ-022 Changes on multiplier while tr=0 SHALL have no effect.
REQ-023 In IDLE with tr=0, all outputs SHALL hold their reset values and the state SHALL remain IDLE.

Reset
REQ-024 reset=0 SHALL immediately, independent of clk, force state=IDLE, count=0, cf=0, done_pulse=0, busy=0 and mult_q=0.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abandon the phase.
- After release, the block SHALL stay in IDLE until a tr=1 edge.
REQ-026 The first clk edge after reset rises SHALL be treated as a normal edge, with tr sampled as usual.

Verification (TVALUE=4)
REQ-027 tr=1 for 1 cycle with multiplier=2, hold=0 -> busy=1 and count=1..8 on successive edges; cf=1 and done_pulse=1 after the 8th edge; done_pulse=0 after the 9th edge; cf stays 1.
REQ-028 tr=1 with multiplier=0 -> cf=1, done_pulse=1 and busy=0 after that same edge; count=0.
REQ-029 multiplier=1 run with hold=1 for 3 edges at count=2 -> count stays 2 during hold; cf rises after the 7th post-tr edge.
REQ-030 multiplier=3 run, tr=1 again at count=5 with multiplier=1 -> count=0 and cf=0; cf rises 4 edges after tr falls.
REQ-031 reset=0 pulse between edges at count=6 of a multiplier=3 run -> all outputs 0 immediately; after release with tr=0 for 10 edges -> state IDLE and cf=0.
REQ-032 In DONE, tr=1 for 3 cycles with multiplier=1 -> cf=0 and count=0 throughout; count=1..4 after tr falls; cf=1 after the 4th edge.

Source files
------------

// File: rtl/phase_timer_if.sv
// Control and status bundle between the crosswalk FSM and phase_timer.
// The count width is derived from TVALUE the same way the timer derives it.
interface phase_timer_if #(
  parameter int TVALUE = 4
);
  localparam int CW = $clog2(3 * TVALUE + 1);

  logic          tr;
  logic [1:0]    multiplier;
  logic          hold;
  logic          cf;
  logic          done_pulse;
  logic          busy;
  logic [CW-1:0] count;

  // Crosswalk FSM side: issues restarts and holds, watches completion.
  modport master (
    output tr, multiplier, hold,
    input  cf, done_pulse, busy, count
  );

  // Timer side.
  modport slave (
    input  tr, multiplier, hold,
    output cf, done_pulse, busy, count
  );
endinterface

// File: rtl/phase_timer.sv
// Phase timer: counts TVALUE*multiplier unheld edges after a restart request,
// then parks in DONE with cf high. Every output comes straight from a flop.
module phase_timer #(
  parameter int TVALUE = 4
) (
  input  logic         clk,
  input  logic         reset,
  phase_timer_if.slave bus
);
  localparam int CW = $clog2(3 * TVALUE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mult_q, mult_d;
  logic [CW-1:0] count_q, count_d;
  logic          cf_q, cf_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] terminal;
  logic [CW-1:0] count_inc;

  // Largest product is 3*TVALUE, which CW is sized to hold exactly.
  assign terminal  = CW'(TVALUE * int'(mult_q));
  assign count_inc = count_q + CW'(1);

  // State and output registers; reset abandons any phase in progress.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mult_q  <= 2'd0;
      count_q <= '0;
      cf_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mult_q  <= mult_d;
      count_q <= count_d;
      cf_q    <= cf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: restart dominates everything, otherwise run until terminal.
  // NOTE: default assignment first so no path through the block infers a latch.
  always_comb begin
    state_d = state_q;
    if (bus.tr) begin
      state_d = (bus.multiplier != 2'd0) ? RUN : DONE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (!bus.hold && count_inc == terminal) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next output values: restart clears, counting edges advance, DONE freezes.
  always_comb begin
    mult_d  = mult_q;
    count_d = count_q;
    cf_d    = cf_q;
    done_d  = 1'b0;
    if (bus.tr) begin
      mult_d  = bus.multiplier;
      count_d = '0;
      cf_d    = (bus.multiplier == 2'd0);
      done_d  = (bus.multiplier == 2'd0);
    end else if (state_q == RUN && !bus.hold) begin
      count_d = count_inc;
      if (count_inc == terminal) begin
        cf_d   = 1'b1;
        done_d = 1'b1;
      end
    end
    busy_d = (state_d == RUN);
  end

  assign bus.count      = count_q;
  assign bus.cf         = cf_q;
  assign bus.done_pulse = done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer (TVALUE=4): directed scenarios plus a
// randomized run, all compared against a "remaining edges" reference model.
module tb_phase_timer;
  localparam int TVALUE = 4;
  localparam int CW     = $clog2(3 * TVALUE + 1);

  logic clk;
  logic reset;

  phase_timer_if #(.TVALUE(TVALUE)) pif ();

  phase_timer #(.TVALUE(TVALUE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a phase is "length" edges long; track how many remain.
  bit m_started;
  int m_len;
  int m_rem;
  bit m_pulse;

  logic [CW-1:0] e_count;
  logic          e_cf, e_done, e_busy;

  function automatic void model_reset();
    m_started = 1'b0;
    m_len     = 0;
    m_rem     = 0;
    m_pulse   = 1'b0;
  endfunction

  function automatic void model_edge(bit t, int m, bit h);
    m_pulse = 1'b0;
    if (t) begin
      m_started = 1'b1;
      m_len     = TVALUE * m;
      m_rem     = m_len;
      m_pulse   = (m_len == 0);
    end else if (m_started && m_rem > 0 && !h) begin
      m_rem   = m_rem - 1;
      m_pulse = (m_rem == 0);
    end
  endfunction

  function automatic void model_outputs();
    e_count = m_started ? CW'(m_len - m_rem) : '0;
    e_cf    = m_started && (m_rem == 0);
    e_done  = m_pulse;
    e_busy  = m_started && (m_rem > 0);
  endfunction

  // Drive one edge's inputs, let the edge happen, update the model, settle.
  task automatic step(input bit t, input logic [1:0] m, input bit h);
    pif.tr         = t;
    pif.multiplier = m;
    pif.hold       = h;
    @(posedge clk);
    model_edge(t, int'(m), h);
    model_outputs();
    #1;
  endtask

  // Async reset pulse placed between edges; outputs must clear immediately.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    model_outputs();
    #1;
    checks++;
    if ({pif.cf, pif.done_pulse, pif.busy, pif.count} !== {1'b0, 1'b0, 1'b0, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL %s_async_clear got cf=%b dp=%b busy=%b count=%0d want all 0",
               tag, pif.cf, pif.done_pulse, pif.busy, pif.count);
    end
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    pif.tr         = 1'b0;
    pif.multiplier = 2'd0;
    pif.hold       = 1'b0;
    model_reset();
    model_outputs();
    #3;
    checks++;
    if ({pif.cf, pif.done_pulse, pif.busy, pif.count} !== {1'b0, 1'b0, 1'b0, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_values got cf=%b dp=%b busy=%b count=%0d want all 0",
               pif.cf, pif.done_pulse, pif.busy, pif.count);
    end
    #5;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'(i + 1), 1'b1);
      checks++;
      if ({pif.cf, pif.done_pulse, pif.busy, pif.count} !== {1'b0, 1'b0, 1'b0, {CW{1'b0}}}) begin
        errors++;
        $display("FAIL idle_hold edge%0d got cf=%b dp=%b busy=%b count=%0d want all 0",
                 i, pif.cf, pif.done_pulse, pif.busy, pif.count);
      end
    end
  endtask

  task automatic test_mult2();
    step(1'b1, 2'd2, 1'b0);
    checks++;
    if (pif.busy !== 1'b1 || pif.count !== CW'(0) || pif.cf !== 1'b0) begin
      errors++;
      $display("FAIL m2_start got busy=%b count=%0d cf=%b want 1 0 0", pif.busy, pif.count, pif.cf);
    end
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 2'd3, 1'b0);
      checks++;
      if (pif.count !== CW'(i > 8 ? 8 : i) || pif.cf !== (i >= 8) ||
          pif.done_pulse !== (i == 8) || pif.busy !== (i < 8)) begin
        errors++;
        $display("FAIL m2_edge%0d got count=%0d cf=%b dp=%b busy=%b", i,
                 pif.count, pif.cf, pif.done_pulse, pif.busy);
      end
    end
  endtask

  task automatic test_mult0();
    step(1'b1, 2'd0, 1'b0);
    checks++;
    if ({pif.cf, pif.done_pulse, pif.busy, pif.count} !== {1'b1, 1'b1, 1'b0, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL m0_entry got cf=%b dp=%b busy=%b count=%0d want 1 1 0 0",
               pif.cf, pif.done_pulse, pif.busy, pif.count);
    end
    step(1'b0, 2'd0, 1'b1);
    checks++;
    if (pif.done_pulse !== 1'b0 || pif.cf !== 1'b1) begin
      errors++;
      $display("FAIL m0_after got dp=%b cf=%b want 0 1", pif.done_pulse, pif.cf);
    end
    // Re-entering DONE with multiplier 0 pulses again.
    step(1'b1, 2'd0, 1'b0);
    checks++;
    if (pif.done_pulse !== 1'b1 || pif.cf !== 1'b1) begin
      errors++;
      $display("FAIL m0_repulse got dp=%b cf=%b want 1 1", pif.done_pulse, pif.cf);
    end
  endtask

  task automatic test_hold();
    bit [7:0] hold_pat;
    hold_pat = 8'b0001_1100; // bit k = hold on post-tr edge k (1-based via k-1)
    step(1'b1, 2'd1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 2'd2, hold_pat[i-1]);
      checks++;
      if ({pif.cf, pif.done_pulse, pif.busy, pif.count} !== {e_cf, e_done, e_busy, e_count} ||
          pif.cf !== (i == 7)) begin
        errors++;
        $display("FAIL hold_edge%0d got cf=%b dp=%b busy=%b count=%0d want %b %b %b %0d",
                 i, pif.cf, pif.done_pulse, pif.busy, pif.count, e_cf, e_done, e_busy, e_count);
      end
    end
    checks++;
    if (pif.count !== CW'(4)) begin
      errors++;
      $display("FAIL hold_final_count got %0d want 4", pif.count);
    end
  endtask

  task automatic test_restart();
    step(1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 1'b0);
    checks++;
    if (pif.count !== CW'(5)) begin
      errors++;
      $display("FAIL restart_pre got count=%0d want 5", pif.count);
    end
    step(1'b1, 2'd1, 1'b1);
    checks++;
    if (pif.count !== CW'(0) || pif.cf !== 1'b0 || pif.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear got count=%0d cf=%b busy=%b want 0 0 1", pif.count, pif.cf, pif.busy);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 2'd3, 1'b0);
      checks++;
      if (pif.cf !== (i == 4) || pif.count !== CW'(i)) begin
        errors++;
        $display("FAIL restart_edge%0d got cf=%b count=%0d want %b %0d", i, pif.cf, pif.count, i == 4, i);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b0);
    pulse_reset("midrun");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'(i), 1'b0);
      checks++;
      if ({pif.cf, pif.busy, pif.count} !== {1'b0, 1'b0, {CW{1'b0}}}) begin
        errors++;
        $display("FAIL post_reset_idle edge%0d got cf=%b busy=%b count=%0d want 0 0 0",
                 i, pif.cf, pif.busy, pif.count);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 2'd0, 1'b0); // land in DONE
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd1, 1'b0);
      checks++;
      if (pif.cf !== 1'b0 || pif.count !== CW'(0)) begin
        errors++;
        $display("FAIL b2b_tr%0d got cf=%b count=%0d want 0 0", i, pif.cf, pif.count);
      end
    end
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 2'd2, 1'b0);
      checks++;
      if (pif.count !== CW'(i > 4 ? 4 : i) || pif.cf !== (i >= 4)) begin
        errors++;
        $display("FAIL b2b_edge%0d got count=%0d cf=%b", i, pif.count, pif.cf);
      end
    end
  endtask

  task automatic test_random();
    bit t, h;
    logic [1:0] m;
    for (int n = 0; n < 400; n++) begin
      t = ($urandom_range(0, 7) == 0);
      h = ($urandom_range(0, 3) == 0);
      m = 2'($urandom_range(0, 3));
      step(t, m, h);
      checks++;
      if ({pif.cf, pif.done_pulse, pif.busy, pif.count} !== {e_cf, e_done, e_busy, e_count}) begin
        errors++;
        $display("FAIL random_cyc%0d got cf=%b dp=%b busy=%b count=%0d want %b %b %b %0d",
                 n, pif.cf, pif.done_pulse, pif.busy, pif.count, e_cf, e_done, e_busy, e_count);
      end
      if ($urandom_range(0, 59) == 0) pulse_reset("random");
    end
  endtask

  initial begin
    test_reset();
    test_mult2();
    test_mult0();
    test_hold();
    test_restart();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
